io_uart_tx: RTL and testbench

//  Serial output stage downstream of the processor's memory-mapped IO byte.
//  - Each store to the IO address pulses io_write with the stored byte.
//  - The byte is queued in a small FIFO, then serialised as 8N1 UART: 1 start, 8 data LSB-first, 1 stop.
//  - The processor is never stalled: when the FIFO is full, the byte is dropped and flagged.

---
 rtl/io_uart_tx.sv | 212 +++++++++++++++++++++
 tb/tb_io_uart_tx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/io_uart_tx.sv
// io_uart_tx
//   Serial output stage for the processor's memory-mapped IO byte. Each
//   io_write strobe queues io_data in a small FIFO. Queued bytes are sent as
//   8N1 UART frames: one start bit, eight data bits LSB first, one stop bit.
//   A write that finds the FIFO full is dropped and sets the sticky overflow
//   flag, so the processor is never stalled.
//
// Configuration macro
//   IO_UART_TX_PARITY_EN : when defined, an even-parity bit is inserted
//                          between the data bits and the stop bit, giving an
//                          11-bit frame.
//
// Ports
//   clk       in  system clock, rising edge
//   rst_n     in  asynchronous active-low reset
//   io_data   in  [7:0] byte from the IO store
//   io_write  in  one-cycle strobe for each IO store
//   fifo_full out FIFO holds FIFO_DEPTH bytes
//   overflow  out sticky flag: a write was dropped; cleared only by reset
//   busy      out FIFO non-empty or a frame in progress
//   uart_tx   out registered serial line, idles high
module io_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] io_data,
  input  logic       io_write,
  output logic       fifo_full,
  output logic       overflow,
  output logic       busy,
  output logic       uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_C   = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

`ifdef IO_UART_TX_PARITY_EN
  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  state_t        state_r;
  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [7:0]    shift_reg_r;
  logic [2:0]    bit_cnt_r;
  logic [15:0]   baud_cnt_r;
  logic          uart_tx_r;
  logic          overflow_r;
`ifdef IO_UART_TX_PARITY_EN
  logic          parity_r;
`endif

  logic [PW-1:0] count_s;
  logic          empty_s;
  logic          full_s;
  logic          push_s;
  logic          pop_s;
  logic          baud_end_s;
  logic [7:0]    head_s;

  // Pointers wrap naturally, so the difference is the occupancy.
  assign count_s    = wr_ptr_r - rd_ptr_r;
  assign empty_s    = (count_s == {PW{1'b0}});
  assign full_s     = (count_s == DEPTH_C);
  assign push_s     = io_write & ~full_s;
  assign baud_end_s = (baud_cnt_r == BAUD_LAST);
  assign head_s     = mem_r[rd_ptr_r[AW-1:0]];
  // Pop only from registered occupancy: a byte pushed this edge is seen next edge.
  assign pop_s      = ~empty_s & ((state_r == ST_IDLE) | ((state_r == ST_STOP) & baud_end_s));

  assign fifo_full  = full_s;
  assign busy       = ~empty_s | (state_r != ST_IDLE);
  assign overflow   = overflow_r;
  assign uart_tx    = uart_tx_r;

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= io_data;
    end
  end

  // Write pointer and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {PW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      // Dropped even if a pop frees a slot at this same edge.
      if (io_write && full_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Read pointer advances whenever the transmitter takes a byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {PW{1'b0}};
    end else if (pop_s) begin
      rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Frame sequencer with registered serial output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      shift_reg_r <= 8'h00;
      bit_cnt_r   <= 3'd0;
      baud_cnt_r  <= 16'd0;
      uart_tx_r   <= 1'b1;
`ifdef IO_UART_TX_PARITY_EN
      parity_r    <= 1'b0;
`endif
    end else begin
      if (pop_s) begin
        // Load the next byte and open its start bit.
        shift_reg_r <= head_s;
        baud_cnt_r  <= 16'd0;
        uart_tx_r   <= 1'b0;
        state_r     <= ST_START;
`ifdef IO_UART_TX_PARITY_EN
        parity_r    <= even_parity(head_s);
`endif
      end else begin
        case (state_r)
          ST_IDLE: begin
            uart_tx_r <= 1'b1;
          end
          ST_START: begin
            if (baud_end_s) begin
              baud_cnt_r <= 16'd0;
              bit_cnt_r  <= 3'd0;
              uart_tx_r  <= shift_reg_r[0];
              state_r    <= ST_DATA;
            end else begin
              baud_cnt_r <= baud_cnt_r + 16'd1;
            end
          end
          ST_DATA: begin
            if (baud_end_s) begin
              baud_cnt_r <= 16'd0;
              if (bit_cnt_r == 3'd7) begin
`ifdef IO_UART_TX_PARITY_EN
                uart_tx_r <= parity_r;
                state_r   <= ST_PARITY;
`else
                uart_tx_r <= 1'b1;
                state_r   <= ST_STOP;
`endif
              end else begin
                shift_reg_r <= shift_reg_r >> 1;
                uart_tx_r   <= shift_reg_r[1];
                bit_cnt_r   <= bit_cnt_r + 3'd1;
              end
            end else begin
              baud_cnt_r <= baud_cnt_r + 16'd1;
            end
          end
`ifdef IO_UART_TX_PARITY_EN
          ST_PARITY: begin
            if (baud_end_s) begin
              baud_cnt_r <= 16'd0;
              uart_tx_r  <= 1'b1;
              state_r    <= ST_STOP;
            end else begin
              baud_cnt_r <= baud_cnt_r + 16'd1;
            end
          end
`endif
          ST_STOP: begin
            // A non-empty FIFO at stop end is handled by pop_s above.
            if (baud_end_s) begin
              baud_cnt_r <= 16'd0;
              uart_tx_r  <= 1'b1;
              state_r    <= ST_IDLE;
            end else begin
              baud_cnt_r <= baud_cnt_r + 16'd1;
            end
          end
          default: begin
            baud_cnt_r <= 16'd0;
            uart_tx_r  <= 1'b1;
            state_r    <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx
//   Randomised and directed stimulus for io_uart_tx, checked every cycle
//   against a frame-timeline reference model (queue of bytes + position in
//   the current frame). Define IO_UART_TX_PARITY_EN for the parity build.
module tb_io_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef IO_UART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] io_data;
  logic       io_write;
  logic       fifo_full;
  logic       overflow;
  logic       busy;
  logic       uart_tx;

  int n_checks;
  int n_fail;

  // reference model state
  logic [7:0] q_m[$];
  bit         active_m;
  int         pos_m;
  logic       ovf_m;
  logic       fb_m [0:10];

  io_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .io_data(io_data), .io_write(io_write),
    .fifo_full(fifo_full), .overflow(overflow), .busy(busy), .uart_tx(uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Frame bit sequence for one byte, straight from the line format.
  task automatic start_frame(input logic [7:0] d);
    fb_m[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb_m[1 + i] = d[i];
`ifdef IO_UART_TX_PARITY_EN
    fb_m[9]  = ^d;
    fb_m[10] = 1'b1;
`else
    fb_m[9]  = 1'b1;
    fb_m[10] = 1'b1;
`endif
    active_m = 1'b1;
    pos_m    = 0;
  endtask

  task automatic model_reset();
    q_m.delete();
    active_m = 1'b0;
    pos_m    = 0;
    ovf_m    = 1'b0;
  endtask

  // One rising edge of the model, using pre-edge occupancy for both decisions.
  task automatic model_edge(input logic wr, input logic [7:0] d);
    int  pre_cnt;
    bit  pre_full;
    pre_cnt  = q_m.size();
    pre_full = (pre_cnt == DEPTH);
    if (active_m) begin
      pos_m++;
      if (pos_m == FRAME * CPB) begin
        if (pre_cnt > 0) start_frame(q_m.pop_front());
        else active_m = 1'b0;
      end
    end else if (pre_cnt > 0) begin
      start_frame(q_m.pop_front());
    end
    if (wr) begin
      if (pre_full) ovf_m = 1'b1;
      else q_m.push_back(d);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic exp_tx;
    exp_tx = active_m ? fb_m[pos_m / CPB] : 1'b1;
    check_eq({tag, ".uart_tx"}, {31'd0, uart_tx}, {31'd0, exp_tx});
    check_eq({tag, ".busy"}, {31'd0, busy}, {31'd0, (q_m.size() > 0) || active_m});
    check_eq({tag, ".fifo_full"}, {31'd0, fifo_full}, {31'd0, q_m.size() == DEPTH});
    check_eq({tag, ".overflow"}, {31'd0, overflow}, {31'd0, ovf_m});
  endtask

  task automatic step(input string tag, input logic wr, input logic [7:0] d);
    @(negedge clk);
    io_write = wr;
    io_data  = d;
    @(posedge clk);
    model_edge(wr, d);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] b;
    n_checks = 0;
    n_fail   = 0;
    io_write = 1'b0;
    io_data  = 8'h00;
    rst_n    = 1'b0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: quiet line after reset
    idle("quiet", 100);

    // 2: single byte, latency and bit order
    step("a5", 1'b1, 8'hA5);
    idle("a5", 50);

    // 3: back-to-back frames
    step("b2b", 1'b1, 8'h01);
    step("b2b", 1'b1, 8'h02);
    step("b2b", 1'b1, 8'h03);
    idle("b2b", 3 * FRAME * CPB + 10);

    // 4: overflow with 6 consecutive writes
    for (int i = 0; i < 6; i++) step("ovf", 1'b1, 8'h10 + 8'(i));
    check_eq("ovf.sticky", {31'd0, overflow}, 32'd1);
    idle("ovf", 5 * FRAME * CPB + 10);
    check_eq("ovf.idle_end", {31'd0, busy}, 32'd0);

    // 5: async reset mid DATA of 0xFF with two bytes queued
    step("rst", 1'b1, 8'hFF);
    step("rst", 1'b1, 8'h11);
    step("rst", 1'b1, 8'h22);
    idle("rst", 12);
    @(negedge clk);
    io_write = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("rst.assert");
    @(negedge clk);
    rst_n = 1'b1;
    idle("rst.after", 60);

    // 6: randomised traffic, including occasional bursts into a full FIFO
    for (int i = 0; i < 1500; i++) begin
      b = 8'($urandom);
      step("rand", ($urandom_range(0, 99) < 9) ? 1'b1 : 1'b0, b);
    end
    idle("drain", (DEPTH + 1) * FRAME * CPB + 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
